bitrev_reorder_pp: RTL and testbench

Streaming bit-reversal reorder buffer with ping-pong double buffering. It is the successor of the single-size bitrev stage. It accepts FFT output samples in natural order and emits them in bit-reversed order, or in natural order when bypassing. Frame size is selectable at run time per frame, up to 2^KMax. It sits between the FFT datapath and the OBI-facing result logic in the user domain, so one frame can be written while the previous one is read.

---
 rtl/bitrev_reorder_pp.sv | 150 +++++++++++++++
 tb/tb_bitrev_reorder_pp.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitrev_reorder_pp.sv
// bitrev_reorder_pp: ping-pong bit-reversal reorder buffer.
// Accepts natural-order frames of 2^k samples (k chosen per frame, clamped to KMax)
// and emits them bit-reversed or in natural order while the next frame is written.
// Optional build macro BITREV_REORDER_FRAMECNT_EN adds frame_cnt_o and drop_o.
module bitrev_reorder_pp #(
  parameter int unsigned KMax = 6,
  parameter int unsigned DW   = 32,
  parameter int unsigned LW   = $clog2(KMax + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [LW-1:0]     log2n_i,
  input  logic              mode_i,
  input  logic              valid_i,
  input  logic [DW-1:0]     data_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DW-1:0]     data_o,
  output logic              last_o,
  input  logic              ready_i,
`ifdef BITREV_REORDER_FRAMECNT_EN
  output logic [15:0]       frame_cnt_o,
  output logic              drop_o,
`endif
  output logic [1:0]        full_o
);

  localparam int unsigned AW    = KMax;
  localparam int unsigned Depth = 2 ** KMax;

  // Index of the final sample of a 2^k frame (all ones in the low k bits).
  function automatic logic [AW-1:0] last_idx(input logic [LW-1:0] k);
    return ~({AW{1'b1}} << k);
  endfunction

  // Reverse the low k bits of a; higher bits come out zero.
  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a, input logic [LW-1:0] k);
    logic [AW-1:0] r;
    for (int i = 0; i < int'(AW); i++) begin
      r[i] = a[AW-1-i];
    end
    return r >> (LW'(AW) - k);
  endfunction

  logic [DW-1:0] mem [2][Depth];
  logic [LW-1:0] cfg_k [2];
  logic [1:0]    cfg_mode;
  logic          wr_bank;
  logic          rd_bank;
  logic          in_frame;
  logic [AW-1:0] w_cnt;
  logic [AW-1:0] r_cnt;
  logic [1:0]    full;

  logic [LW-1:0] keff;
  logic [LW-1:0] wr_k;
  logic [LW-1:0] rd_k;
  logic [AW-1:0] rd_addr;
  logic          wr_hs;
  logic          wr_last;
  logic          rd_hs;
  logic          rd_last;
  logic [1:0]    full_nxt;

  // Handshakes, read addressing and next full flags, all derived from registers.
  always_comb begin
    keff     = (log2n_i > LW'(KMax)) ? LW'(KMax) : log2n_i;
    wr_k     = in_frame ? cfg_k[wr_bank] : keff;
    ready_o  = ~full[wr_bank];
    wr_hs    = valid_i & ready_o;
    wr_last  = wr_hs & (w_cnt == last_idx(wr_k));

    rd_k     = cfg_k[rd_bank];
    valid_o  = full[rd_bank];
    last_o   = valid_o & (r_cnt == last_idx(rd_k));
    rd_hs    = valid_o & ready_i;
    rd_last  = rd_hs & last_o;
    rd_addr  = cfg_mode[rd_bank] ? bitrev(r_cnt, rd_k) : r_cnt;
    data_o   = valid_o ? mem[rd_bank][rd_addr] : '0;

    full_nxt = full;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
  end

  assign full_o = full;

  // Sample storage; contents survive reset, writes are suppressed while in reset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && wr_hs) begin
      mem[wr_bank][w_cnt] <= data_i;
    end
  end

  // Write/read pointers, bank selection, per-bank config and full flags.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      in_frame <= 1'b0;
      w_cnt    <= '0;
      r_cnt    <= '0;
      full     <= 2'b00;
      cfg_k[0] <= '0;
      cfg_k[1] <= '0;
      cfg_mode <= 2'b00;
    end else begin
      if (wr_hs) begin
        if (!in_frame) begin
          cfg_k[wr_bank]    <= keff;
          cfg_mode[wr_bank] <= mode_i;
        end
        if (wr_last) begin
          wr_bank  <= ~wr_bank;
          w_cnt    <= '0;
          in_frame <= 1'b0;
        end else begin
          w_cnt    <= w_cnt + AW'(1);
          in_frame <= 1'b1;
        end
      end
      if (rd_hs) begin
        if (last_o) begin
          rd_bank <= ~rd_bank;
          r_cnt   <= '0;
        end else begin
          r_cnt   <= r_cnt + AW'(1);
        end
      end
      full <= full_nxt;
    end
  end

`ifdef BITREV_REORDER_FRAMECNT_EN
  logic [15:0] frame_cnt;

  // Count of fully drained frames, wrapping at 16 bits.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      frame_cnt <= '0;
    end else if (rd_last) begin
      frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign frame_cnt_o = frame_cnt;
  assign drop_o      = valid_i & ~ready_o;
`endif

endmodule

// File: tb/tb_bitrev_reorder_pp.sv
// Scoreboard bench for bitrev_reorder_pp: a frame-level model pushes expected
// output samples; a monitor pops and compares on every output handshake.
module tb_bitrev_reorder_pp;
  localparam int unsigned KMax = 6;
  localparam int unsigned DW   = 32;
  localparam int unsigned LW   = 3;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic [LW-1:0] log2n_i = '0;
  logic          mode_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          ready_o;
  logic          valid_o;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic          ready_i = 1'b1;
  logic [1:0]    full_o;
`ifdef BITREV_REORDER_FRAMECNT_EN
  logic [15:0]   frame_cnt_o;
  logic          drop_o;
`endif

  bitrev_reorder_pp #(.KMax(KMax), .DW(DW)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_ni),
    .log2n_i (log2n_i),
    .mode_i  (mode_i),
    .valid_i (valid_i),
    .data_i  (data_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .data_o  (data_o),
    .last_o  (last_o),
    .ready_i (ready_i),
`ifdef BITREV_REORDER_FRAMECNT_EN
    .frame_cnt_o (frame_cnt_o),
    .drop_o      (drop_o),
`endif
    .full_o  (full_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] cur_q[$];
  int  nchk = 0;
  int  nerr = 0;
  int  done_cnt = 0;
  int  read_cnt = 0;
  bit  in_frame_m = 1'b0;
  int  k_m = 0;
  bit  mode_m = 1'b0;
  bit  rnd_ready = 1'b0;

  function automatic void check(input string name, input longint act, input longint exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int rev_bits(input int i, input int k);
    int r = 0;
    for (int b = 0; b < k; b++) begin
      if (((i >> b) & 1) != 0) r |= (1 << (k - 1 - b));
    end
    return r;
  endfunction

  // Input-side model: collects each frame and queues its output order once complete.
  always @(negedge clk) begin
    if (!rst_ni) begin
      exp_q.delete();
      cur_q.delete();
      in_frame_m = 1'b0;
      done_cnt <= 0;
    end else begin
      check("ready_o", longint'(ready_o), longint'((done_cnt - read_cnt) < 2));
`ifdef BITREV_REORDER_FRAMECNT_EN
      check("drop_o", longint'(drop_o), longint'(valid_i && ((done_cnt - read_cnt) == 2)));
`endif
      if (valid_i && ready_o) begin
        if (!in_frame_m) begin
          k_m = (int'(log2n_i) > int'(KMax)) ? int'(KMax) : int'(log2n_i);
          mode_m = mode_i;
          in_frame_m = 1'b1;
        end
        cur_q.push_back(data_i);
        if (cur_q.size() == (1 << k_m)) begin
          for (int i = 0; i < (1 << k_m); i++) begin
            exp_t e;
            e.data = cur_q[mode_m ? rev_bits(i, k_m) : i];
            e.last = (i == (1 << k_m) - 1);
            exp_q.push_back(e);
          end
          cur_q.delete();
          in_frame_m = 1'b0;
          done_cnt <= done_cnt + 1;
        end
      end
    end
  end

  // Output monitor: status flags every cycle, sample/last against the queue head.
  always @(negedge clk) begin
    if (!rst_ni) begin
      read_cnt <= 0;
    end else begin
      check("valid_o", longint'(valid_o), longint'((done_cnt - read_cnt) > 0));
      check("full_count", longint'($countones(full_o)), longint'(done_cnt - read_cnt));
`ifdef BITREV_REORDER_FRAMECNT_EN
      check("frame_cnt_o", longint'(frame_cnt_o), longint'(read_cnt % 65536));
`endif
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", longint'(valid_o), 0);
        end else begin
          exp_t e;
          e = exp_q[0];
          check("data_o", longint'(data_o), longint'(e.data));
          check("last_o", longint'(last_o), longint'(e.last));
          if (ready_i) begin
            void'(exp_q.pop_front());
            if (e.last) read_cnt <= read_cnt + 1;
          end
        end
      end else begin
        check("idle_data", longint'({last_o, data_o}), 0);
      end
    end
  end

  // Random read-side back-pressure while enabled.
  always @(posedge clk) begin
    if (rnd_ready) begin
      #1;
      ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic wr(input logic [DW-1:0] d, input int k, input bit m);
    int t = 0;
    bit hs = 1'b0;
    data_i  = d;
    log2n_i = LW'(k);
    mode_i  = m;
    valid_i = 1'b1;
    do begin
      @(negedge clk);
      hs = ready_o;
      @(posedge clk);
      #1;
      t++;
    end while (!hs && t < 1000);
    check("wr_handshake", longint'(hs), 1);
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || done_cnt != read_cnt) && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check("drain", longint'(exp_q.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    check("rst_valid", longint'(valid_o), 0);
    check("rst_ready", longint'(ready_o), 1);
    check("rst_full", longint'(full_o), 0);
    check("rst_data", longint'(data_o), 0);
    check("rst_last", longint'(last_o), 0);

    // Bit-reversed 8-sample frame with first-output latency.
    for (int i = 0; i < 7; i++) wr(DW'(i), 3, 1'b1);
    check("pre_valid", longint'(valid_o), 0);
    wr(DW'(7), 3, 1'b1);
    check("first_valid", longint'(valid_o), 1);
    check("first_data", longint'(data_o), 0);
    drain();

    // Natural-order 4-sample frame.
    for (int i = 0; i < 4; i++) wr(DW'(10 + i), 2, 1'b0);
    drain();

    // Ping-pong with both banks filled under back-pressure.
    ready_i = 1'b0;
    for (int i = 0; i < 8; i++) wr(DW'(i), 3, 1'b1);
    for (int i = 0; i < 4; i++) wr(DW'(100 + i), 2, 1'b1);
    check("pp_ready", longint'(ready_o), 0);
    check("pp_full", longint'(full_o), 3);
    ready_i = 1'b1;
    drain();

    // Size change mid-frame is ignored until the next frame.
    wr(DW'(30), 3, 1'b1);
    wr(DW'(31), 3, 1'b1);
    for (int i = 2; i < 8; i++) wr(DW'(30 + i), 1, 1'b0);
    check("midcfg_valid", longint'(valid_o), 1);
    wr(DW'(50), 1, 1'b0);
    wr(DW'(51), 1, 1'b0);
    drain();

    // Clamp to KMax and single-sample frames.
    for (int i = 0; i < 64; i++) wr(DW'(i), 7, 1'b1);
    drain();
    for (int i = 0; i < 3; i++) wr(DW'(300 + i), 0, 1'b1);
    drain();

    // Reset with one full bank and a partial frame.
    ready_i = 1'b0;
    for (int i = 0; i < 8; i++) wr(DW'(i), 3, 1'b1);
    for (int i = 0; i < 5; i++) wr(DW'(20 + i), 3, 1'b0);
    rst_ni = 1'b0;
    @(posedge clk);
    #1 rst_ni = 1'b1;
    check("mrst_valid", longint'(valid_o), 0);
    check("mrst_ready", longint'(ready_o), 1);
    check("mrst_full", longint'(full_o), 0);
`ifdef BITREV_REORDER_FRAMECNT_EN
    check("mrst_frame_cnt", longint'(frame_cnt_o), 0);
`endif
    repeat (3) @(posedge clk);
    #1 ready_i = 1'b1;
    for (int i = 0; i < 8; i++) wr(DW'(400 + i), 3, 1'b1);
    for (int f = 0; f < 2; f++) begin
      wr(DW'(500 + 2 * f), 1, 1'b1);
      wr(DW'(501 + 2 * f), 1, 1'b1);
    end
    drain();
`ifdef BITREV_REORDER_FRAMECNT_EN
    check("frame_cnt_3", longint'(frame_cnt_o), 3);
`endif

    // Randomized frames, sizes, modes, gaps and back-pressure.
    rnd_ready = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int k;
      int n;
      bit m;
      k = int'($urandom_range(0, 7));
      m = bit'($urandom_range(0, 1));
      n = 1 << ((k > int'(KMax)) ? int'(KMax) : k);
      for (int i = 0; i < n; i++) begin
        wr($urandom, (i == 0) ? k : int'($urandom_range(0, 7)), (i == 0) ? m : bit'($urandom_range(0, 1)));
        if ($urandom_range(0, 7) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rnd_ready = 1'b0;
    @(posedge clk);
    #2 ready_i = 1'b1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
